// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// BURST beats into a downstream FIFO, with registered write strobe and data.
module fifo_wr_arb #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int DEPTH = 16,
    parameter int BURST = 4,
    localparam int IDW = $clog2(NREQ),
    localparam int LW  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  fifo_wr_en,
    output logic [WIDTH+IDW-1:0]  fifo_din,
    input  logic                  fifo_full,
    input  logic [LW-1:0]         fifo_level,
    input  logic [LW-1:0]         afull_thresh,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy,
    output logic                  throttled
);
    // Handshake: a beat moves when req_valid[i] && req_ready[i] at a rising edge;
    // only the granted requester ever sees req_ready, and only in GRANT.
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_next;
    logic [IDW-1:0]   last_grant;
    logic [CW-1:0]    beat_cnt;
    logic [IDW-1:0]   pick_id;
    logic             pick_found;
    logic [IDW-1:0]   rr_idx;
    logic [LW:0]      lvl_sum;
    logic             space_ok;
    logic             level_ok;
    logic             cur_valid;
    logic [WIDTH-1:0] cur_data;
    logic             accept;
    logic             last_beat;
    logic             grant_go;

    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        rr_idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = IDW'((int'(last_grant) + k) % NREQ);
            if (!pick_found && req_valid[rr_idx]) begin
                pick_found = 1'b1;
                pick_id    = rr_idx;
            end
        end
    end

    // One extra bit so level + in-flight write cannot wrap.
    assign lvl_sum   = {1'b0, fifo_level} + (LW+1)'(fifo_wr_en);
    assign space_ok  = (lvl_sum < (LW+1)'(DEPTH)) && !fifo_full;
    assign level_ok  = fifo_level < afull_thresh;
    assign cur_valid = req_valid[grant_id];
    assign cur_data  = req_data[int'(grant_id)*WIDTH +: WIDTH];
    assign accept    = (state == GRANT) && cur_valid && space_ok;
    assign last_beat = beat_cnt == CW'(BURST - 1);
    assign grant_go  = (state == IDLE) && pick_found && level_ok;
    assign busy      = state == GRANT;
    // Gated by rst so the flag drops with the asynchronous reset.
    assign throttled = rst && (state == IDLE) && (|req_valid) && !level_ok;

    always_comb begin
        req_ready = '0;
        if (state == GRANT) req_ready[grant_id] = space_ok;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_go) state_next = GRANT;
            GRANT:   if (!cur_valid || (accept && last_beat)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= IDW'(NREQ - 1);
            grant_id   <= '0;
            beat_cnt   <= '0;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
        end else begin
            fifo_wr_en <= accept;
            if (grant_go) begin
                grant_id   <= pick_id;
                last_grant <= pick_id;
                beat_cnt   <= '0;
            end
            if (accept) begin
                fifo_din <= {grant_id, cur_data};
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
endmodule
